dff_write_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among N requesters. It grants write ownership of the register to one requester at a time and caps each ownership at MAX_HOLD writes for fairness. The registered value is published on q. The block sits in front of the shared register bank in the Behaviour datapath and replaces ad-hoc muxing of d inputs.

---
 rtl/dff_write_arbiter_if.sv | 19 +
 rtl/dff_write_arbiter.sv | 122 ++++++++++++
 tb/tb_dff_write_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dff_write_arbiter_if.sv
// Bus bundle between the requesters and the shared-register write arbiter.
// The master side drives requests and data, and the slave side (the arbiter)
// returns grant, ownership and the register contents.
interface dff_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] d_in;
  logic [N-1:0]       grant;
  logic [OW-1:0]      owner;
  logic               busy;
  logic [WIDTH-1:0]   q;

  modport master (output req, d_in, input grant, owner, busy, q);
  modport slave  (input req, d_in, output grant, owner, busy, q);
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter for a single shared WIDTH-bit register.
// One requester owns the register at a time. An ownership ends after MAX_HOLD
// writes, or as soon as the owner drops its request. Every output is registered.
module dff_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic            clock,
  input  logic            reset,
  dff_write_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [OW-1:0]    ptr, ptr_n;
  logic [OW-1:0]    owner_r, owner_n;
  logic [N-1:0]     grant_r, grant_n;
  logic [3:0]       cnt, cnt_n;
  logic [WIDTH-1:0] q_r, q_n;

  logic             hit;
  logic [OW-1:0]    pick;
  logic [OW-1:0]    cand;
  logic [WIDTH-1:0] owner_data;
  logic [OW-1:0]    after_owner;

  // Round-robin search: first requester at or after ptr, with wrap-around
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = OW'((32'(ptr) + k) % N);
      if (!hit && bus.req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  // Select the current owner's data slice
  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_r == OW'(i)) owner_data = bus.d_in[i*WIDTH +: WIDTH];
    end
  end

  // Rotation point after a release, so that the released requester is ranked last
  always_comb begin
    after_owner = (owner_r == OW'(N - 1)) ? '0 : owner_r + OW'(1);
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner_r;
    grant_n = grant_r;
    cnt_n   = cnt;
    q_n     = q_r;
    case (state)
      IDLE: begin
        if (hit) begin
          state_n       = BUSY;
          owner_n       = pick;
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          cnt_n         = '0;
        end
      end
      BUSY: begin
        if (bus.req[owner_r]) begin
          q_n   = owner_data;
          cnt_n = cnt + 4'd1;
          // The write that reaches the cap also releases on the same edge
          if (cnt + 4'd1 == 4'(MAX_HOLD)) begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = after_owner;
          end
        end else begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = after_owner;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath registers: shared register, grant, owner, pointer, hold counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      owner_r <= '0;
      grant_r <= '0;
      cnt     <= '0;
      q_r     <= '0;
    end else begin
      ptr     <= ptr_n;
      owner_r <= owner_n;
      grant_r <= grant_n;
      cnt     <= cnt_n;
      q_r     <= q_n;
    end
  end

  assign bus.grant = grant_r;
  assign bus.owner = owner_r;
  assign bus.busy  = (state == BUSY);
  assign bus.q     = q_r;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_dff_write_arbiter;
  localparam int WIDTH    = 8;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clock;
  logic reset;

  dff_write_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  dff_write_arbiter #(.WIDTH(WIDTH), .N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the register, how many writes are used, rotation start
  int              m_busy, m_owner, m_ptr, m_used;
  logic [WIDTH-1:0] m_q;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_used = 0; m_q = '0;
  endtask

  task automatic model_release();
    m_busy = 0;
    m_ptr  = (m_owner + 1) % N;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N*WIDTH-1:0] d);
    if (m_busy == 0) begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          m_busy = 1; m_owner = (m_ptr + k) % N; m_used = 0;
          break;
        end
      end
    end else if (r[m_owner]) begin
      m_q    = d[m_owner*WIDTH +: WIDTH];
      m_used = m_used + 1;
      if (m_used == MAX_HOLD) model_release();
    end else begin
      model_release();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_busy != 0) ? (N'(1) << m_owner) : '0;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(m_owner));
    chk({tag, ".busy"},  32'(bus.busy),  32'(m_busy));
    chk({tag, ".q"},     32'(bus.q),     32'(m_q));
  endtask

  // One clock: inputs change on the falling edge, checked 1 time unit after the rising edge
  task automatic cycle(input logic rst, input logic [N-1:0] r,
                       input logic [N*WIDTH-1:0] d, input string tag);
    @(negedge clock);
    reset    = rst;
    bus.req  = r;
    bus.d_in = d;
    @(posedge clock);
    #1;
    if (rst) model_reset();
    else     model_edge(r, d);
    check_all(tag);
  endtask

  logic [N*WIDTH-1:0] dv;
  logic [N-1:0]       rv;
  int                 p, idx;

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.d_in = '0;
    model_reset();

    // 1: reset held with random inputs, then released with no requests
    for (int c = 0; c < 2; c++) cycle(1'b1, N'($urandom), {$urandom}, "rst_hold");
    for (int c = 0; c < 2; c++) cycle(1'b0, '0, {$urandom}, "rst_idle");

    // 2: single requester, one write then voluntary release
    dv = '0; dv[7:0] = 8'hA5;
    cycle(1'b0, 4'b0001, dv, "t2_e0");
    chk("t2_grant_e0", 32'(bus.grant), 32'h1);
    cycle(1'b0, 4'b0001, dv, "t2_e1");
    chk("t2_q_e1", 32'(bus.q), 32'hA5);
    cycle(1'b0, 4'b0000, dv, "t2_e2");
    chk("t2_grant_e2", 32'(bus.grant), 32'h0);
    cycle(1'b0, 4'b0000, '0, "t2_e3");
    chk("t2_q_hold", 32'(bus.q), 32'hA5);

    // 3: full contention, forced releases every MAX_HOLD writes
    cycle(1'b1, '0, '0, "t3_rst");
    dv = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 1; c <= 20; c++) begin
      cycle(1'b0, 4'b1111, dv, "t3");
      p   = (c - 1) % 5;
      idx = (c - 1) / 5;
      chk("t3_grant", 32'(bus.grant), (p < 4) ? (32'h1 << idx) : 32'h0);
      chk("t3_q", 32'(bus.q), (p >= 1) ? 32'((idx + 1) * 8'h11) : 32'(idx * 8'h11));
    end

    // 4: owner 3 was just force-released; rotation wraps to requester 0
    cycle(1'b0, 4'b1001, dv, "t4");
    chk("t4_grant", 32'(bus.grant), 32'h1);

    // 5: owner 1 drops its request after two writes
    cycle(1'b1, '0, '0, "t5_rst");
    dv = {8'h00, 8'hC3, 8'h5A, 8'h00};
    cycle(1'b0, 4'b0110, dv, "t5_g");
    chk("t5_grant1", 32'(bus.grant), 32'h2);
    cycle(1'b0, 4'b0110, dv, "t5_w1");
    cycle(1'b0, 4'b0110, dv, "t5_w2");
    chk("t5_q_w2", 32'(bus.q), 32'h5A);
    cycle(1'b0, 4'b0100, dv, "t5_rel");
    chk("t5_grant_rel", 32'(bus.grant), 32'h0);
    chk("t5_q_rel", 32'(bus.q), 32'h5A);
    cycle(1'b0, 4'b0100, dv, "t5_g2");
    chk("t5_grant2", 32'(bus.grant), 32'h4);

    // 6: asynchronous reset between edges before the third write lands
    cycle(1'b1, '0, '0, "t6_rst");
    dv = {8'h9C, 8'h7E, 8'h3D, 8'hB1};
    cycle(1'b0, 4'b1111, dv, "t6_g");
    cycle(1'b0, 4'b1111, dv, "t6_w1");
    cycle(1'b0, 4'b1111, dv, "t6_w2");
    chk("t6_q_pre", 32'(bus.q), 32'hB1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_async_q", 32'(bus.q), 32'h0);
    chk("t6_async_busy", 32'(bus.busy), 32'h0);
    cycle(1'b0, 4'b0100, dv, "t6_after");
    chk("t6_grant_after", 32'(bus.grant), 32'h4);

    // Random traffic with occasional resets
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 6) rv = N'($urandom_range(0, (1 << N) - 1));
      for (int b = 0; b < N; b++) dv[b*WIDTH +: WIDTH] = WIDTH'($urandom);
      cycle(($urandom_range(0, 59) == 0), rv, dv, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
